// File: rtl/dmem_arbiter.sv
// dmem_arbiter: single-port data RAM shared by the CPU memory stage and an external loader port
module dmem_arbiter #(
  parameter int DMEM_POWER = 18,
  parameter int MAX_WAIT   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        ext_req,
  input  logic        ext_we,
  input  logic [31:0] ext_addr,
  input  logic [31:0] ext_wdata,
  output logic [31:0] ext_rdata,
  output logic        ext_ack
);
  typedef enum logic [1:0] {READY, CPU_RD, EXT_RD} state_t;
  localparam logic [3:0] MW = 4'(MAX_WAIT);
  state_t state_q, state_d;
  logic [3:0] wait_q, wait_d;
  logic [31:0] rd_q, rd_d;
  logic [31:0] mem [2**DMEM_POWER];
  logic ready, cpu_win, ext_win, win_we, mem_we;
  logic [DMEM_POWER-1:0] win_idx;
  logic [31:0] win_wdata;
  logic unused_bits;
  assign unused_bits = ^{cpu_addr[31:DMEM_POWER+2], cpu_addr[1:0], ext_addr[31:DMEM_POWER+2], ext_addr[1:0]};
  // Grants are suppressed while reset is held so nothing touches the RAM.
  always_comb begin
    ready     = state_q == READY && !reset;
    ext_win   = ready && ext_req && (!cpu_req || wait_q == MW);
    cpu_win   = ready && cpu_req && !ext_win;
    win_we    = ext_win ? ext_we : cpu_we;
    win_idx   = ext_win ? ext_addr[DMEM_POWER+1:2] : cpu_addr[DMEM_POWER+1:2];
    win_wdata = ext_win ? ext_wdata : cpu_wdata;
    mem_we    = (cpu_win || ext_win) && win_we;
    rd_d      = (cpu_win || ext_win) && !win_we ? mem[win_idx] : rd_q;
    state_d   = cpu_win && !cpu_we ? CPU_RD : ext_win && !ext_we ? EXT_RD : READY;
    wait_d    = ext_win ? 4'd0 : (ready && ext_req && wait_q != MW) ? wait_q + 4'd1 : wait_q;
    cpu_stall = cpu_req && !(cpu_win && cpu_we) && state_q != CPU_RD;
    ext_ack   = (ext_win && ext_we) || state_q == EXT_RD;
    cpu_rdata = rd_q;
    ext_rdata = rd_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= READY;
      wait_q  <= 4'd0;
      rd_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      rd_q    <= rd_d;
    end
  end
  always_ff @(posedge clk) begin
    if (mem_we) mem[win_idx] <= win_wdata;
  end
endmodule
